fifo_to_axi: RTL and testbench
==============================

Name: fifo_to_axi

Overview:
- Write-direction DMA engine: pops data words from a FIFO and writes them to memory as AXI4 INCR write bursts (AW/W/B).
- Started by a one-cycle start pulse carrying byte address and byte length; signals completion with a done pulse plus error flag.
- Sits beside the memory-read-to-FIFO engine on the same AXI port; one burst outstanding at a time.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width; legal values 32/64/128. BYTES = AXI_DATA_WIDTH/8.
- LEN_WIDTH, 16, byte-length width.
- AWCACHE, 4'b0010, constant driven on awcache.

Ports:
- clock  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request pulse; ignored while busy
- addr  in  AXI_ADDR_WIDTH  destination byte address; must be BYTES-aligned
- len  in  LEN_WIDTH  byte count
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; held until next done
- fifo_rd_data  in  AXI_DATA_WIDTH  FWFT FIFO head word
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop head word (combinational)
- awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awid/awcache/awlock/awprot/awqos/awvalid  out  AXI AW
- awready  in  1
- wdata  out  AXI_DATA_WIDTH; wstrb  out  BYTES; wlast/wvalid  out  1
- wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset values: busy=0, done=0, error=0, awvalid=0, wvalid=0, wlast=0, bready=0, fifo_rd_en=0. Reset mid-operation aborts immediately to IDLE; the FIFO is not flushed.
- Constants: awid=0, awsize=log2(BYTES), awburst=INCR (2'b01), awlock=0, awprot=0, awqos=0, awcache=AWCACHE.
- Accept: start && !busy.
  - If len==0 or addr[log2(BYTES)-1:0]!=0: done=1 and error=1 on the next cycle; busy stays 0; no AXI activity.
  - Otherwise latch addr and total_beats = ceil(len/BYTES); rem = len mod BYTES; busy=1; clear the sticky bresp error; go to AW.
- FSM states: IDLE -> AW -> W -> B -> (AW | IDLE).
- AW state:
  - Burst beats nb = min(256, beats_left, (4096 - cur_addr[11:0]) / BYTES). Bursts never cross a 4KB boundary.
  - awaddr=cur_addr, awlen=nb-1.
  - awvalid asserted the cycle after entering AW, held until awready; then go to W.
- W state:
  - Registered output stage. wvalid/wdata are loaded from the FIFO when (!wvalid || wready) && !fifo_empty && beats still to issue in the burst; fifo_rd_en=1 in exactly that cycle.
  - Data is held stable while wvalid && !wready. FIFO empty leaves wvalid low; no beat is dropped or duplicated.
  - wlast=1 on beat nb. wstrb is all ones, except on the final beat of the whole transfer when rem!=0: wstrb = (1<<rem)-1.
  - After the wlast handshake go to B; wvalid=0.
- B state:
  - bready=1 until bvalid.
  - bresp!=2'b00 sets the sticky error; the remaining bursts are still issued.
  - Then cur_addr += nb*BYTES and beats_left -= nb. If beats_left != 0, go to AW; else done=1, error=sticky, busy=0, go to IDLE.
- Latency: start to awvalid = 2 cycles. Exactly total_beats FIFO pops per transfer.

Test Plan:
- BYTES=4, addr=0x1000, len=16, FIFO preloaded -> one AW with awlen=3; 4 W beats, wstrb=0xF, wlast on beat 4; done=1, error=0 after bvalid.
- addr=0x0, len=1030 -> AW awlen=255 @0x0, then AW awlen=1 @0x400; final beat wstrb=0x3; 258 pops total.
- addr=0x0F00, len=512 -> AW awlen=63 @0x0F00, then AW awlen=63 @0x1000 (4KB split).
- FIFO empty for 5 cycles mid-burst, plus wready low for 3 cycles -> wvalid low while empty; wdata stable while stalled; memory image matches the FIFO sequence exactly.
- len=0, and separately addr=0x1002 -> done=1 and error=1 one cycle after start; awvalid never asserted.
- Two-burst transfer with bresp=SLVERR on burst 1 -> burst 2 still written; done with error=1. Then reset asserted mid-W -> all outputs return to reset values.

Source files
------------

// File: rtl/fifo_to_axi_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_to_axi_if
// Description : AXI4 write-channel bundle (AW/W/B) between the FIFO-to-AXI
//               DMA engine (master) and the memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_to_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awid;
    logic [3:0]          awcache;
    logic                awlock;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awcache, awlock, awprot,
               awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awcache, awlock, awprot,
               awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_to_axi.sv
`default_nettype none
// ============================================================================
// Module      : fifo_to_axi
// Description : Write-direction DMA engine. Pops words from an FWFT FIFO and
//               writes them to memory as AXI4 INCR bursts, one burst in
//               flight, never crossing a 4KB page.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_to_axi #(
    parameter int         AXI_ADDR_WIDTH = 32,
    parameter int         AXI_DATA_WIDTH = 32,
    parameter int         LEN_WIDTH      = 16,
    parameter logic [3:0] AWCACHE        = 4'b0010
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic [AXI_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    fifo_to_axi_if.master             axi
);
    localparam int BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]      beats_left_q, beats_left_d;
    logic [BSHIFT-1:0]         rem_q, rem_d;
    logic [8:0]                nb_q, nb_d;          // beats in current burst
    logic [8:0]                issued_q, issued_d;  // beats loaded into W stage
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]          wstrb_q, wstrb_d;
    logic                      wlast_q, wlast_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic                      sticky_q, sticky_d;  // any bresp error this transfer

    logic [12:0]               w_page_beats;
    logic [8:0]                w_cap;
    logic [8:0]                w_nb;
    logic [LEN_WIDTH-1:0]      w_total_beats;
    logic [BYTES-1:0]          w_part_strb;
    logic                      w_load;
    logic                      w_resp_err;

    // Beats left in the current 4KB page, capped at the AXI4 maximum of 256,
    // then limited by what remains of the transfer.
    assign w_page_beats  = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> BSHIFT;
    assign w_cap         = (w_page_beats > 13'd256) ? 9'd256 : w_page_beats[8:0];
    assign w_nb          = (beats_left_q < LEN_WIDTH'(w_cap)) ? beats_left_q[8:0] : w_cap;
    assign w_total_beats = (len >> BSHIFT) + LEN_WIDTH'(|len[BSHIFT-1:0]);
    assign w_resp_err    = (axi.bresp != 2'b00);

    // Byte mask for a trailing partial word: low rem bytes enabled.
    always_comb begin
        w_part_strb = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_part_strb[i] = (i < int'(rem_q));
        end
    end

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        rem_d        = rem_q;
        nb_d         = nb_q;
        issued_d     = issued_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wlast_d      = wlast_q;
        done_d       = 1'b0;
        error_d      = error_q;
        sticky_d     = sticky_q;
        w_load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((len == '0) || (addr[BSHIFT-1:0] != '0)) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        cur_addr_d   = addr;
                        beats_left_d = w_total_beats;
                        rem_d        = len[BSHIFT-1:0];
                        sticky_d     = 1'b0;
                        state_d      = S_AW;
                    end
                end
            end
            S_AW: begin
                // First AW cycle sizes the burst; awvalid follows a cycle later.
                if (!awvalid_q) begin
                    nb_d      = w_nb;
                    awvalid_d = 1'b1;
                end else if (axi.awready) begin
                    awvalid_d = 1'b0;
                    issued_d  = 9'd0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                w_load = (!wvalid_q || axi.wready) && !fifo_empty && (issued_q != nb_q);
                if (w_load) begin
                    wvalid_d = 1'b1;
                    wdata_d  = fifo_rd_data;
                    issued_d = issued_q + 9'd1;
                    wlast_d  = (issued_q + 9'd1 == nb_q);
                    // Last beat of the whole transfer carries the partial mask.
                    if ((issued_q + 9'd1 == nb_q) && (LEN_WIDTH'(nb_q) == beats_left_q)
                        && (rem_q != '0)) begin
                        wstrb_d = w_part_strb;
                    end else begin
                        wstrb_d = '1;
                    end
                end else if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    if (wlast_q) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (axi.bvalid) begin
                    sticky_d     = sticky_q | w_resp_err;
                    cur_addr_d   = cur_addr_q + (AXI_ADDR_WIDTH'(nb_q) << BSHIFT);
                    beats_left_d = beats_left_q - LEN_WIDTH'(nb_q);
                    if (beats_left_q == LEN_WIDTH'(nb_q)) begin
                        done_d  = 1'b1;
                        error_d = sticky_q | w_resp_err;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_AW;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            rem_q        <= '0;
            nb_q         <= '0;
            issued_q     <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wlast_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            rem_q        <= rem_d;
            nb_q         <= nb_d;
            issued_q     <= issued_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wlast_q      <= wlast_d;
            done_q       <= done_d;
            error_q      <= error_d;
            sticky_q     <= sticky_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign fifo_rd_en  = w_load;

    assign axi.awaddr  = cur_addr_q;
    assign axi.awlen   = 8'(nb_q - 9'd1);
    assign axi.awsize  = 3'(BSHIFT);
    assign axi.awburst = 2'b01;
    assign axi.awid    = 1'b0;
    assign axi.awcache = AWCACHE;
    assign axi.awlock  = 1'b0;
    assign axi.awprot  = 3'b000;
    assign axi.awqos   = 4'b0000;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == S_B);
endmodule
`default_nettype wire

// File: tb/tb_fifo_to_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_to_axi
// Description : Self-checking bench for fifo_to_axi: FIFO + AXI slave model,
//               burst/beat reference queues and a memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_to_axi;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int BYTES = 4;

    typedef struct { logic [31:0] a; logic [7:0] l; } aw_t;
    typedef struct { logic [31:0] d; logic [3:0] s; logic last; } w_t;

    logic          clock = 1'b0;
    logic          reset_n, start;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          busy, done, error;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty, fifo_rd_en;

    fifo_to_axi_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    fifo_to_axi #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LEN_WIDTH(LW), .AWCACHE(4'b0010)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .error(error),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .axi(axi)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    aw_t         exp_aw[$];
    aw_t         obs_aw[$];
    w_t          exp_w[$];
    logic [31:0] fifo_q[$];
    logic [31:0] mem[int unsigned];
    logic [31:0] exp_mem[int unsigned];

    bit   rnd_mode = 0, stall_mode = 0;
    int   err_burst = -1;
    int   pops = 0, b_count = 0, w_seen = 0, wb = 0;
    int   st_e = 0, st_w = 0;
    bit   st_e_done = 0, st_w_done = 0;
    bit   awvalid_seen = 0;
    logic [3:0] last_ws = 4'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bursts, beats, FIFO content and final memory image.
    task automatic build(input logic [31:0] a, input int l, output int nbursts);
        int unsigned cur, left, nb, pg, beats, rem, g;
        aw_t t;
        w_t  w;
        logic [31:0] d;
        fifo_q.delete(); exp_w.delete(); exp_aw.delete(); obs_aw.delete();
        mem.delete(); exp_mem.delete();
        pops = 0; b_count = 0; w_seen = 0; wb = 0;
        st_e = 0; st_w = 0; st_e_done = 0; st_w_done = 0;
        beats = (l + BYTES - 1) / BYTES;
        rem = l % BYTES;
        cur = a; left = beats; g = 0; nbursts = 0;
        while (left > 0) begin
            nb = 256;
            if (left < nb) nb = left;
            pg = (4096 - (cur % 4096)) / BYTES;
            if (pg < nb) nb = pg;
            t.a = cur; t.l = 8'(nb - 1);
            exp_aw.push_back(t);
            nbursts++;
            for (int unsigned k = 0; k < nb; k++) begin
                d = $urandom;
                fifo_q.push_back(d);
                w.d = d;
                w.last = (k == nb - 1);
                w.s = (g == beats - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
                exp_w.push_back(w);
                exp_mem[cur + k * 4] = d;
                g++;
            end
            cur += nb * 4;
            left -= nb;
        end
        // Spare words: an over-pop would surface as an unexpected beat.
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
    endtask

    // FIFO and AXI slave model plus per-cycle protocol/data comparison.
    initial begin
        bit aw_hs, w_hs, b_hs, pop, wlast_s, rst_ok;
        bit prev_ok, prev_stall, prev_free, prev_empty;
        logic [31:0] prev_data;
        logic [3:0]  prev_strb;
        logic        prev_last;
        int b_delay;
        bit b_pend;
        aw_t e;
        w_t  ew;
        int unsigned waddr;
        prev_ok = 0; prev_stall = 0; prev_free = 0; prev_empty = 0;
        prev_data = 0; prev_strb = 0; prev_last = 0; b_delay = 0; b_pend = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
        fifo_empty = 1; fifo_rd_data = 0;
        forever begin
            @(negedge clock);
            rst_ok = reset_n;
            aw_hs = 0; w_hs = 0; b_hs = 0; pop = 0; wlast_s = 0;
            if (reset_n) begin
                if (axi.awvalid) awvalid_seen = 1;
                if (prev_ok && prev_stall) begin
                    chk("w_hold_valid", axi.wvalid, 1);
                    chk("w_hold_data", axi.wdata, prev_data);
                    chk("w_hold_strb", axi.wstrb, prev_strb);
                    chk("w_hold_last", axi.wlast, prev_last);
                end
                if (prev_ok && prev_free && prev_empty) chk("w_idle_when_empty", axi.wvalid, 0);
                if (fifo_empty) chk("no_pop_when_empty", fifo_rd_en, 0);
                if (axi.bvalid) chk("bready_with_bvalid", axi.bready, 1);
                aw_hs = axi.awvalid && axi.awready;
                w_hs  = axi.wvalid && axi.wready;
                b_hs  = axi.bvalid && axi.bready;
                pop   = fifo_rd_en;
                wlast_s = axi.wlast;
                if (aw_hs) begin
                    e.a = axi.awaddr; e.l = axi.awlen;
                    obs_aw.push_back(e);
                    chk("aw_const", {axi.awsize, axi.awburst, axi.awid, axi.awcache,
                                     axi.awlock, axi.awprot, axi.awqos},
                        {3'd2, 2'b01, 1'b0, 4'b0010, 1'b0, 3'd0, 4'd0});
                    if (exp_aw.size() == 0) begin
                        chk("aw_unexpected", aw_hs, 0);
                    end else begin
                        e = exp_aw.pop_front();
                        chk("awaddr", axi.awaddr, e.a);
                        chk("awlen", axi.awlen, e.l);
                    end
                    wb = 0;
                end
                if (w_hs) begin
                    if (obs_aw.size() != 0) begin
                        waddr = obs_aw[obs_aw.size() - 1].a + wb * 4;
                        mem[waddr] = axi.wdata;
                    end
                    wb++; w_seen++;
                    last_ws = axi.wstrb;
                    if (exp_w.size() == 0) begin
                        chk("w_unexpected", w_hs, 0);
                    end else begin
                        ew = exp_w.pop_front();
                        chk("wdata", axi.wdata, ew.d);
                        chk("wstrb", axi.wstrb, ew.s);
                        chk("wlast", axi.wlast, ew.last);
                    end
                end
                prev_stall = axi.wvalid && !axi.wready;
                prev_free  = !axi.wvalid || axi.wready;
                prev_empty = fifo_empty;
                prev_data  = axi.wdata;
                prev_strb  = axi.wstrb;
                prev_last  = axi.wlast;
            end
            prev_ok = reset_n;
            @(posedge clock);
            #1;
            if (!rst_ok) begin
                b_pend = 0;
                axi.bvalid = 0;
            end else begin
                if (pop && fifo_q.size() != 0) begin
                    void'(fifo_q.pop_front());
                    pops++;
                end
                if (b_hs) begin
                    axi.bvalid = 0;
                    b_count++;
                end
                if (w_hs && wlast_s) begin
                    b_pend = 1;
                    b_delay = rnd_mode ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (b_pend && !axi.bvalid) begin
                if (b_delay == 0) begin
                    axi.bvalid = 1;
                    axi.bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end else begin
                    b_delay--;
                end
            end
            if (stall_mode && w_seen >= 4 && !st_e_done) begin st_e = 5; st_e_done = 1; end
            if (stall_mode && w_seen >= 8 && !st_w_done) begin st_w = 3; st_w_done = 1; end
            fifo_empty   = (fifo_q.size() == 0) || (st_e > 0) || (rnd_mode && $urandom_range(0, 3) == 0);
            fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
            axi.wready   = (st_w == 0) && (!rnd_mode || $urandom_range(0, 2) != 0);
            axi.awready  = !rnd_mode || $urandom_range(0, 1) == 1;
            if (st_e > 0) st_e--;
            if (st_w > 0) st_w--;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_awvalid"}, axi.awvalid, 0);
        chk({tag, "_wvalid"}, axi.wvalid, 0);
        chk({tag, "_wlast"}, axi.wlast, 0);
        chk({tag, "_bready"}, axi.bready, 0);
        chk({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    endtask

    task automatic pulse_start(input logic [31:0] a, input int l);
        @(posedge clock); #1;
        start = 1; addr = a; len = LW'(l);
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic wait_done(input int budget, input bit exp_e);
        int n = 0;
        bit got = 0;
        while (!got && n < budget) begin
            @(negedge clock);
            n++;
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("done_error", error, exp_e);
            chk("done_busy", busy, 0);
        end
        @(negedge clock);
        chk("done_pulse", done, 0);
        chk("error_held", error, exp_e);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int l);
        int nbursts, beats, bad;
        bit exp_e;
        build(a, l, nbursts);
        beats = (l + BYTES - 1) / BYTES;
        exp_e = (err_burst >= 0) && (err_burst < nbursts);
        pulse_start(a, l);
        @(negedge clock);
        chk("lat_awvalid_c1", axi.awvalid, 0);
        chk("lat_busy_c1", busy, 1);
        @(negedge clock);
        chk("lat_awvalid_c2", axi.awvalid, 1);
        wait_done(beats * 20 + 200, exp_e);
        chk("aw_all_issued", exp_aw.size(), 0);
        chk("w_all_issued", exp_w.size(), 0);
        chk("pop_count", pops, beats);
        bad = 0;
        foreach (exp_mem[k]) if (!mem.exists(k) || mem[k] !== exp_mem[k]) bad++;
        chk("mem_image", bad, 0);
        chk("mem_size", mem.size(), exp_mem.size());
    endtask

    task automatic bad_req(input logic [31:0] a, input int l);
        awvalid_seen = 0;
        pulse_start(a, l);
        @(negedge clock);
        chk("bad_done", done, 1);
        chk("bad_error", error, 1);
        chk("bad_busy", busy, 0);
        repeat (5) @(negedge clock);
        chk("bad_no_aw", awvalid_seen, 0);
        chk("bad_busy_after", busy, 0);
    endtask

    // Directed and randomized scenario sequence.
    initial begin
        int  seen;
        int  nb_dummy;
        reset_n = 0; start = 0; addr = '0; len = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        @(posedge clock); #1;
        reset_n = 1;

        // Single burst, everything ready.
        run_xfer(32'h1000, 16);
        chk("t1_aw_count", obs_aw.size(), 1);
        if (obs_aw.size() >= 1) begin
            chk("t1_awaddr", obs_aw[0].a, 32'h1000);
            chk("t1_awlen", obs_aw[0].l, 8'd3);
        end
        chk("t1_last_wstrb", last_ws, 4'hF);

        // 256-beat cap and trailing partial word.
        run_xfer(32'h0, 1030);
        chk("t2_aw_count", obs_aw.size(), 2);
        if (obs_aw.size() >= 2) begin
            chk("t2_aw0_addr", obs_aw[0].a, 32'h0);
            chk("t2_aw0_len", obs_aw[0].l, 8'd255);
            chk("t2_aw1_addr", obs_aw[1].a, 32'h400);
            chk("t2_aw1_len", obs_aw[1].l, 8'd1);
        end
        chk("t2_pops", pops, 258);
        chk("t2_last_wstrb", last_ws, 4'h3);

        // 4KB page split with random back-pressure.
        rnd_mode = 1;
        run_xfer(32'h0F00, 512);
        chk("t3_aw_count", obs_aw.size(), 2);
        if (obs_aw.size() >= 2) begin
            chk("t3_aw0_addr", obs_aw[0].a, 32'h0F00);
            chk("t3_aw0_len", obs_aw[0].l, 8'd63);
            chk("t3_aw1_addr", obs_aw[1].a, 32'h1000);
            chk("t3_aw1_len", obs_aw[1].l, 8'd63);
        end

        // FIFO underrun and wready stall mid-burst.
        rnd_mode = 0; stall_mode = 1;
        run_xfer(32'h2000, 64);
        chk("t4_stalls_hit", {st_e_done, st_w_done}, 2'b11);
        stall_mode = 0;

        // Illegal requests.
        bad_req(32'h1000, 0);
        bad_req(32'h1002, 8);

        // Slave error on the first of two bursts.
        err_burst = 0;
        run_xfer(32'h3000, 1200);
        chk("t6_aw_count", obs_aw.size(), 2);
        err_burst = -1;

        // Randomized transfers.
        rnd_mode = 1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            int l, eb;
            a  = ({24'h0, 8'($urandom_range(0, 255))} << 12) | (32'($urandom_range(0, 1023)) << 2);
            l  = int'($urandom_range(1, 1500));
            eb = int'($urandom_range(0, 3));
            err_burst = (eb == 3) ? -1 : eb;
            run_xfer(a, l);
        end
        err_burst = -1;

        // Reset in the middle of the W phase.
        rnd_mode = 0;
        build(32'h4000, 64, nb_dummy);
        pulse_start(32'h4000, 64);
        seen = 0;
        for (int n = 0; n < 50 && seen == 0; n++) begin
            @(negedge clock);
            if (axi.wvalid) seen = 1;
        end
        chk("t7_saw_wvalid", seen, 1);
        @(posedge clock); #1;
        reset_n = 0;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("midw_reset");
        @(posedge clock); #1;
        reset_n = 1;

        // Recovery after reset.
        run_xfer(32'h5000, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
